// File: rtl/la_rstseq_pkg.sv
// ------------------------------------------------------------------
// la_rstseq_pkg : state encodings and sizing helpers for la_rstseq
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package la_rstseq_pkg;

   typedef logic [1:0] state_t;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_UP   = 2'd1;
   localparam logic [1:0] ST_ON   = 2'd2;
   localparam logic [1:0] ST_DOWN = 2'd3;

   // lvl must hold 0..N inclusive
   function automatic int lvl_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/la_rsync.sv
// ------------------------------------------------------------------
// la_rsync : reset synchronizer, asserts async and releases sync
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module la_rsync #(
   parameter int SYNC = 2,
   parameter     PROP = "DEFAULT"
) (
   input  logic clk,
   input  logic nrst_in,
   output logic nrst_out
);

   logic [SYNC-1:0] sync_q;

   always_ff @(posedge clk or negedge nrst_in) begin
      if (!nrst_in) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC-2:0], 1'b1};
      end
   end

   assign nrst_out = sync_q[SYNC-1];

endmodule

`default_nettype wire

// File: rtl/la_rstseq.sv
// ------------------------------------------------------------------
// la_rstseq : staged reset sequencer for N async-reset domains
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module la_rstseq
   import la_rstseq_pkg::*;
#(
   parameter int N    = 4,
   parameter int CW   = 8,
   parameter int SYNC = 2,
   parameter     PROP = "DEFAULT"
) (
   input  logic          clk,
   input  logic          nreset,
   input  logic          en,
   input  logic          req_off,
   input  logic [CW-1:0] delay,
   output logic [N-1:0]  nrst_out,
   output logic          busy,
   output logic          done
);

   localparam int            LW      = lvl_width(N);
   localparam logic [LW-1:0] LVL_MAX = LW'(N);

   logic          rst_s;
   state_t        state, state_nxt;
   logic [LW-1:0] lvl, lvl_nxt;
   logic [CW-1:0] timer, timer_nxt;
   logic [CW-1:0] dly_q, dly_nxt;
   logic [N-1:0]  nrst_nxt;
   logic          step;

   la_rsync #(
      .SYNC (SYNC),
      .PROP (PROP)
   ) u_rsync (
      .clk      (clk),
      .nrst_in  (nreset),
      .nrst_out (rst_s)
   );

   assign step = (timer == dly_q);

   always_comb begin
      state_nxt = state;
      lvl_nxt   = lvl;
      timer_nxt = timer;
      dly_nxt   = dly_q;
      case (state)
         ST_IDLE: begin
            if (en && !req_off) begin
               state_nxt = ST_UP;
               dly_nxt   = delay;
               timer_nxt = '0;
            end
         end
         ST_UP: begin
            // shutdown request wins over a step due on the same edge
            if (req_off) begin
               state_nxt = ST_DOWN;
               dly_nxt   = delay;
               timer_nxt = '0;
            end else if (en) begin
               if (step) begin
                  lvl_nxt   = lvl + LW'(1);
                  timer_nxt = '0;
                  if (lvl_nxt == LVL_MAX) begin
                     state_nxt = ST_ON;
                  end
               end else begin
                  timer_nxt = timer + CW'(1);
               end
            end
         end
         ST_ON: begin
            if (req_off) begin
               state_nxt = ST_DOWN;
               dly_nxt   = delay;
               timer_nxt = '0;
            end
         end
         default: begin
            if (lvl == '0) begin
               state_nxt = ST_IDLE;
            end else if (step) begin
               lvl_nxt   = lvl - LW'(1);
               timer_nxt = '0;
               if (lvl_nxt == '0) begin
                  state_nxt = ST_IDLE;
               end
            end else begin
               timer_nxt = timer + CW'(1);
            end
         end
      endcase
   end

   // outputs decode the next level so a step appears on the edge it occurs
   for (genvar i = 0; i < N; i++) begin : g_dec
      assign nrst_nxt[i] = (LW'(i) < lvl_nxt);
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state    <= ST_IDLE;
         lvl      <= '0;
         timer    <= '0;
         dly_q    <= '0;
         nrst_out <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else if (rst_s) begin
         state    <= state_nxt;
         lvl      <= lvl_nxt;
         timer    <= timer_nxt;
         dly_q    <= dly_nxt;
         nrst_out <= nrst_nxt;
         busy     <= (state_nxt == ST_UP) || (state_nxt == ST_DOWN);
         done     <= (state_nxt == ST_ON);
      end
   end

endmodule

`default_nettype wire
